// File: rtl/byte_serial_mem_responder_if.sv
// Bus bundle between a byte-serial word initiator and the memory-side responder.
// A transfer happens on a posedge where valid and ready are both 1; the initiator keeps valid and data stable until then.
interface byte_serial_mem_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  wbyte_valid;
  logic [7:0]            wbyte;
  logic                  wbyte_ready;
  logic                  rbyte_valid;
  logic [7:0]            rbyte;
  logic                  rbyte_ready;
  logic                  done;

  modport master (
    output req_valid, req_write, req_addr, wbyte_valid, wbyte, rbyte_ready,
    input  req_ready, wbyte_ready, rbyte_valid, rbyte, done
  );

  modport slave (
    input  req_valid, req_write, req_addr, wbyte_valid, wbyte, rbyte_ready,
    output req_ready, wbyte_ready, rbyte_valid, rbyte, done
  );
endinterface

// File: rtl/byte_serial_mem_responder.sv
// Memory-side responder: collects/returns 32-bit words as four MSB-first bytes
// over a byte-serial handshake, backed by an internal word-wide RAM.
module byte_serial_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  byte_serial_mem_responder_if.slave   bus,
  output logic [2:0]                   dbg_state
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_COMMIT  = 3'd2,
    RD_FETCH   = 3'd3,
    RD_SEND    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      shift_q;
  logic [31:0]      mem [MEM_DEPTH];
  logic             wr_hs, rd_hs;

  // Only the word-index bits of req_addr matter; the rest wrap or are byte offsets.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr;

  assign dbg_state = state_q;

  always_comb begin
    state_d         = state_q;
    wr_hs           = (state_q == WR_COLLECT) && bus.wbyte_valid;
    rd_hs           = (state_q == RD_SEND) && bus.rbyte_ready;
    bus.req_ready   = !reset && (state_q == IDLE);
    bus.wbyte_ready = !reset && (state_q == WR_COLLECT);
    bus.rbyte_valid = !reset && (state_q == RD_SEND);
    bus.rbyte       = reset ? 8'h00 : shift_q[31:24];
    bus.done        = !reset && ((state_q == WR_COMMIT) || (rd_hs && byte_cnt_q == 2'd3));
    case (state_q)
      IDLE:       if (bus.req_valid) state_d = bus.req_write ? WR_COLLECT : RD_FETCH;
      WR_COLLECT: if (wr_hs && byte_cnt_q == 2'd3) state_d = WR_COMMIT;
      WR_COMMIT:  state_d = IDLE;
      RD_FETCH:   state_d = RD_SEND;
      RD_SEND:    if (rd_hs && byte_cnt_q == 2'd3) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            idx_q      <= bus.req_addr[IDX_W+1:2];
            byte_cnt_q <= 2'd0;
          end
        end
        WR_COLLECT: begin
          if (wr_hs) begin
            shift_q    <= {shift_q[23:0], bus.wbyte};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        RD_FETCH: begin
          shift_q    <= mem[idx_q];
          byte_cnt_q <= 2'd0;
        end
        RD_SEND: begin
          if (rd_hs) begin
            shift_q    <= {shift_q[23:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; a commit interrupted by reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == WR_COMMIT) mem[idx_q] <= shift_q;
  end
endmodule

// File: tb/tb_byte_serial_mem_responder.sv
// Randomized scoreboard bench for byte_serial_mem_responder against a word-array model.
module tb_byte_serial_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int exp_done = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] ref_mem [int];

  bit         prev_hold = 0;
  logic [7:0] prev_byte = 8'h00;

  byte_serial_mem_responder_if #(.ADDR_WIDTH(16)) bus ();

  byte_serial_mem_responder #(.ADDR_WIDTH(16), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_idx(logic [15:0] addr);
    return int'((addr / 4) % 256);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 0;
    end else begin
      if (bus.done) done_seen++;
      if (bus.rbyte_valid) begin
        if (prev_hold) check("rbyte_stable", {24'd0, bus.rbyte}, {24'd0, prev_byte});
        if (bus.rbyte_ready) begin
          if (exp_q.size() == 0) check("rbyte_unexpected", {24'd0, bus.rbyte}, 32'hFFFF_FFFF);
          else check("rbyte", {24'd0, bus.rbyte}, {24'd0, exp_q.pop_front()});
        end
        prev_hold = !bus.rbyte_ready;
        prev_byte = bus.rbyte;
      end else begin
        prev_hold = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(bit wr, logic [15:0] addr);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(logic [15:0] addr, logic [31:0] data, int gap);
    request(1'b1, addr);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bus.wbyte_valid = 1'b0;
        @(negedge clk);
        check("wbyte_ready_gap", {31'd0, bus.wbyte_ready}, 32'd1);
        tick();
      end
      bus.wbyte_valid = 1'b1;
      bus.wbyte = data[31-8*b -: 8];
      @(negedge clk);
      check("wbyte_ready", {31'd0, bus.wbyte_ready}, 32'd1);
      tick();
    end
    bus.wbyte_valid = 1'b0;
    @(negedge clk);
    check("wr_done", {31'd0, bus.done}, 32'd1);
    ref_mem[word_idx(addr)] = data;
    exp_done++;
    tick();
  endtask

  // mode 0: always ready, 1: pattern 1,0,0 repeating, 2: random
  task automatic do_read(logic [15:0] addr, int mode, bit poke);
    int hs = 0;
    int cyc = 1;
    int k = 0;
    bit got_done = 0;
    logic [31:0] w;
    request(1'b0, addr);
    w = ref_mem[word_idx(addr)];
    for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    if (poke) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
    end
    while (!got_done && cyc < 200) begin
      case (mode)
        0:       bus.rbyte_ready = 1'b1;
        1:       bus.rbyte_ready = (k % 3 == 0);
        default: bus.rbyte_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (poke) check("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
      if (bus.rbyte_valid) begin
        k++;
        if (bus.rbyte_ready) begin
          hs++;
          if (hs == 4) begin
            got_done = 1;
            check("rd_done", {31'd0, bus.done}, 32'd1);
            if (mode == 0) check("rd_latency", cyc, 5);
          end
        end
      end
      tick();
      cyc++;
    end
    if (!got_done) check("rd_timeout", 32'd0, 32'd1);
    exp_done++;
    bus.rbyte_ready = 1'b0;
    if (poke) begin
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("post_busy_idle", {31'd0, bus.req_ready}, 32'd1);
      tick();
      @(negedge clk);
      check("post_busy_no_txn", {29'd0, dbg_state}, 32'd0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = 16'h0000;
    bus.wbyte_valid = 1'b0;
    bus.wbyte       = 8'h00;
    bus.rbyte_ready = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("idle_state", {29'd0, dbg_state}, 32'd0);
    check("idle_rbyte", {24'd0, bus.rbyte}, 32'd0);
    tick();

    // write then full-speed read
    do_write(16'h0010, 32'hDEADBEEF, 0);
    do_read(16'h0010, 0, 0);

    // backpressure 1,0,0,...
    do_write(16'h0030, 32'h11223344, 0);
    do_read(16'h0030, 1, 0);

    // gaps and ignored low address bits
    do_write(16'h0023, 32'h01020304, 3);
    do_read(16'h0020, 0, 0);

    // wrap-around
    do_write(16'h0400, 32'hAABBCCDD, 0);
    do_read(16'h0000, 0, 0);
    do_write(16'h03FC, 32'h12345678, 0);
    do_read(16'h03FC, 0, 0);

    // reset mid-write
    do_write(16'h0040, 32'hCAFEF00D, 0);
    request(1'b1, 16'h0040);
    bus.wbyte_valid = 1'b1;
    bus.wbyte = 8'h55;
    tick();
    bus.wbyte = 8'h66;
    tick();
    bus.wbyte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("midrst_wbyte_ready", {31'd0, bus.wbyte_ready}, 32'd0);
    check("midrst_rbyte_valid", {31'd0, bus.rbyte_valid}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_rbyte", {24'd0, bus.rbyte}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    do_read(16'h0040, 0, 0);

    // busy rejection
    do_read(16'h0010, 0, 1);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int idx;
      logic [15:0] addr;
      idx = $urandom_range(0, 7);
      addr = 16'(($urandom_range(0, 63) << 10) | (idx << 2) | $urandom_range(0, 3));
      if (!ref_mem.exists(word_idx(addr)) || $urandom_range(0, 1) == 1)
        do_write(addr, $urandom, $urandom_range(0, 2));
      else
        do_read(addr, $urandom_range(0, 2), 0);
    end

    repeat (3) tick();
    check("done_count", done_seen, exp_done);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
